// File: rtl/murax_reset_seq.sv
// murax_reset_seq: reset sequencer feeding the core's io_asyncReset.
// Merges PLL lock and the user reset button into one stretched reset. That
// reset is released synchronously to CLK. The block also records the cause of
// the last reset entry so software can read it.
//
// Optional build macro: RESET_SEQ_DEBOUNCE_EN
//   defined   - the button passes through a DEBOUNCE_CYCLES consecutive-cycle filter
//   undefined - the synchronized button is used directly; DEBOUNCE_CYCLES is ignored
//
// Ports:
//   CLK          in  main clock (PLL output domain)
//   reset_in     in  asynchronous active-high reset
//   pll_locked   in  PLL lock, asynchronous to CLK
//   button_in    in  raw reset button, high while pressed, asynchronous
//   sys_reset    out active-high core reset, registered; set at once by reset_in
//   locked_sync  out pll_locked after the 2-flop synchronizer
//   reset_cause  out 00 power-on, 01 lock loss, 10 button
module murax_reset_seq #(
   parameter int unsigned HOLD_CYCLES     = 255,
   parameter int unsigned DEBOUNCE_CYCLES = 1023
) (
   input  logic       CLK,
   input  logic       reset_in,
   input  logic       pll_locked,
   input  logic       button_in,
   output logic       sys_reset,
   output logic       locked_sync,
   output logic [1:0] reset_cause
);

   localparam int unsigned HOLD_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [1:0]  CAUSE_POR  = 2'b00;
   localparam logic [1:0]  CAUSE_LOCK = 2'b01;
   localparam logic [1:0]  CAUSE_BTN  = 2'b10;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   // Reject out-of-range configurations at elaboration.
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
       DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
      $error("murax_reset_seq: HOLD_CYCLES/DEBOUNCE_CYCLES out of range 1..65535");
   end

   logic              r_lock_s1;
   logic              r_lock_s2;
   logic              r_btn_s1;
   logic              r_btn_s2;
   logic              r_btn_prev;
   logic              w_btn_stable;
   logic              w_btn_req;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_cnt_nxt;
   logic [1:0]        r_cause;
   logic [1:0]        w_cause_nxt;
   logic              r_sys_reset;
   logic              w_sys_reset_nxt;

   // Two-flop synchronizers for lock and button.
   always_ff @(posedge CLK or posedge reset_in) begin : p_sync
      if (reset_in) begin
         r_lock_s1 <= 1'b0;
         r_lock_s2 <= 1'b0;
         r_btn_s1  <= 1'b0;
         r_btn_s2  <= 1'b0;
      end else begin
         r_lock_s1 <= pll_locked;
         r_lock_s2 <= r_lock_s1;
         r_btn_s1  <= button_in;
         r_btn_s2  <= r_btn_s1;
      end
   end

`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] r_db_cnt;
   logic            r_btn_stable;

   // The stable value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge CLK or posedge reset_in) begin : p_debounce
      if (reset_in) begin
         r_db_cnt     <= '0;
         r_btn_stable <= 1'b0;
      end else if (r_btn_s2 == r_btn_stable) begin
         r_db_cnt     <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         r_btn_stable <= r_btn_s2;
         r_db_cnt     <= '0;
      end else begin
         r_db_cnt     <= r_db_cnt + DB_W'(1);
      end
   end

   assign w_btn_stable = r_btn_stable;
`else
   assign w_btn_stable = r_btn_s2;
`endif

   // The previous stable value gives a one-cycle pulse on release (1->0) only.
   always_ff @(posedge CLK or posedge reset_in) begin : p_btn_edge
      if (reset_in) begin
         r_btn_prev <= 1'b0;
      end else begin
         r_btn_prev <= w_btn_stable;
      end
   end

   assign w_btn_req = r_btn_prev & ~w_btn_stable;

   // FSM state plus registered outputs.
   always_ff @(posedge CLK or posedge reset_in) begin : p_state_reg
      if (reset_in) begin
         r_state     <= ST_WAIT_LOCK;
         r_hold_cnt  <= '0;
         r_cause     <= CAUSE_POR;
         r_sys_reset <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_cause     <= w_cause_nxt;
         r_sys_reset <= w_sys_reset_nxt;
      end
   end

   // Next state; lock loss takes priority over a button release.
   always_comb begin : p_next_state
      w_state_nxt = r_state;
      case (r_state)
         ST_WAIT_LOCK: begin
            if (r_lock_s2) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (!r_lock_s2)                                   w_state_nxt = ST_WAIT_LOCK;
            else if (w_btn_req)                               w_state_nxt = ST_HOLD;
            else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1))  w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!r_lock_s2)     w_state_nxt = ST_WAIT_LOCK;
            else if (w_btn_req) w_state_nxt = ST_HOLD;
         end
         default: w_state_nxt = ST_WAIT_LOCK;
      endcase
   end

   // Hold counter, cause and reset output. The counter stops at HOLD_CYCLES
   // when HOLD is left, so it never wraps.
   always_comb begin : p_outputs
      w_hold_cnt_nxt = r_hold_cnt;
      w_cause_nxt    = r_cause;
      case (r_state)
         ST_WAIT_LOCK: begin
            w_hold_cnt_nxt = '0;
         end
         ST_HOLD: begin
            if (!r_lock_s2) begin
               w_hold_cnt_nxt = '0;
               w_cause_nxt    = CAUSE_LOCK;
            end else if (w_btn_req) begin
               w_hold_cnt_nxt = '0;
               w_cause_nxt    = CAUSE_BTN;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            if (!r_lock_s2) begin
               w_cause_nxt    = CAUSE_LOCK;
            end else if (w_btn_req) begin
               w_hold_cnt_nxt = '0;
               w_cause_nxt    = CAUSE_BTN;
            end
         end
         default: begin
            w_hold_cnt_nxt = '0;
         end
      endcase
      w_sys_reset_nxt = (w_state_nxt != ST_RUN);
   end

   assign sys_reset   = r_sys_reset;
   assign locked_sync = r_lock_s2;
   assign reset_cause = r_cause;

endmodule

// File: tb/tb_murax_reset_seq.sv
// Scoreboard bench for murax_reset_seq (HOLD_CYCLES=8, DEBOUNCE_CYCLES=4).
// Stimulus pushes cycle-stamped expectations; monitors pop and compare them.
module tb_murax_reset_seq;

   localparam int unsigned HOLD = 8;
   localparam int unsigned DEB  = 4;
`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int BTN_LAT = 7;   // release drive -> edge where HOLD is entered
`else
   localparam int BTN_LAT = 3;
`endif

   logic       CLK = 1'b0;
   logic       reset_in;
   logic       pll_locked;
   logic       button_in;
   logic       sys_reset;
   logic       locked_sync;
   logic [1:0] reset_cause;

   murax_reset_seq #(
      .HOLD_CYCLES     (HOLD),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .CLK         (CLK),
      .reset_in    (reset_in),
      .pll_locked  (pll_locked),
      .button_in   (button_in),
      .sys_reset   (sys_reset),
      .locked_sync (locked_sync),
      .reset_cause (reset_cause)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         cyc;     // edge number to check after; -1 = right after reset_in rises
      logic       sr;
      logic [1:0] cz;
      bit         chk_lk;
      logic       lk;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input exp_t e);
      total++;
      if (sys_reset !== e.sr) begin
         bad++;
         $display("FAIL %s sys_reset at edge %0d: got %b want %b", e.nm, cyc, sys_reset, e.sr);
      end
      total++;
      if (reset_cause !== e.cz) begin
         bad++;
         $display("FAIL %s reset_cause at edge %0d: got %b want %b", e.nm, cyc, reset_cause, e.cz);
      end
      if (e.chk_lk) begin
         total++;
         if (locked_sync !== e.lk) begin
            bad++;
            $display("FAIL %s locked_sync at edge %0d: got %b want %b", e.nm, cyc, locked_sync, e.lk);
         end
      end
   endtask

   task automatic push(input int c, input logic sr, input logic [1:0] cz,
                       input bit chk_lk, input logic lk, input string nm);
      exp_t e;
      e.cyc = c; e.sr = sr; e.cz = cz; e.chk_lk = chk_lk; e.lk = lk; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic push_rng(input int c0, input int c1, input logic sr,
                           input logic [1:0] cz, input string nm);
      for (int c = c0; c <= c1; c++) push(c, sr, cz, 1'b0, 1'b0, nm);
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Power-up sequence after reset_in is released at the negedge following edge p.
   task automatic expect_power_up(input int p, input string nm);
      push(p + 1, 1'b1, 2'b00, 1'b1, 1'b0, nm);
      push(p + 2, 1'b1, 2'b00, 1'b1, 1'b1, nm);
      push_rng(p + 3,  p + 10, 1'b1, 2'b00, nm);
      push_rng(p + 11, p + 13, 1'b0, 2'b00, nm);
   endtask

   // Clocked monitor: compares every expectation due at this edge.
   initial begin : mon_clk
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         while (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
               total++;
               bad++;
               $display("FAIL %s missed check for edge %0d (now %0d)", e.nm, e.cyc, cyc);
            end else begin
               check(e);
            end
         end
      end
   end

   // Asynchronous monitor: checks outputs right after reset_in rises.
   initial begin : mon_async
      forever begin
         @(posedge reset_in);
         #1;
         while (q.size() > 0 && q[0].cyc < 0) check(q.pop_front());
      end
   end

   initial begin : stim
      int p;
      int r;
      int u;
      reset_in   = 1'b1;
      pll_locked = 1'b1;
      button_in  = 1'b0;

      // Reset values held while reset_in is high.
      for (int c = 1; c <= 3; c++) push(c, 1'b1, 2'b00, 1'b1, 1'b0, "rst_state");
      wait_neg(3);

      // Power-up with lock steady high: sys_reset falls at edge HOLD+3.
      p = cyc;
      expect_power_up(p, "power_up");
      reset_in = 1'b0;
      wait_neg(13);

      // Lock loss for 20 cycles in RUN.
      p = cyc;
      push(p + 1, 1'b0, 2'b00, 1'b1, 1'b1, "lockloss_sync");
      push(p + 2, 1'b0, 2'b00, 1'b1, 1'b0, "lockloss_sync");
      push_rng(p + 3,  p + 30, 1'b1, 2'b01, "lockloss_hold");
      push_rng(p + 31, p + 33, 1'b0, 2'b01, "lockloss_run");
      pll_locked = 1'b0;
      wait_neg(20);
      pll_locked = 1'b1;
      wait_neg(13);

      // Clean button: pressing has no effect, release gives HOLD cycles of reset.
      p = cyc;
      r = p + 10;
      push_rng(p + 1, r + BTN_LAT - 1, 1'b0, 2'b01, "btn_press");
      push_rng(r + BTN_LAT, r + BTN_LAT + 7, 1'b1, 2'b10, "btn_hold");
      push_rng(r + BTN_LAT + 8, r + BTN_LAT + 10, 1'b0, 2'b10, "btn_run");
      button_in = 1'b1;
      wait_neg(10);
      button_in = 1'b0;
      wait_neg(BTN_LAT + 10);

      // Bounce: 3-cycle pulses for 30 cycles.
      p = cyc;
`ifdef RESET_SEQ_DEBOUNCE_EN
      push_rng(p + 1, p + 40, 1'b0, 2'b10, "bounce");
`else
      push_rng(p + 1,  p + 5,  1'b0, 2'b10, "bounce_pre");
      push_rng(p + 6,  p + 37, 1'b1, 2'b10, "bounce_hold");
      push_rng(p + 38, p + 40, 1'b0, 2'b10, "bounce_run");
`endif
      for (int i = 0; i < 5; i++) begin
         button_in = 1'b1;
         wait_neg(3);
         button_in = 1'b0;
         wait_neg(3);
      end
      wait_neg(10);

      // Button release and lock loss reach the FSM on the same edge while in HOLD.
      p = cyc;
      u = p + 20;
      push_rng(p + 1,  p + 10, 1'b0, 2'b10, "simul_pre");
      push_rng(p + 11, u + 6,  1'b1, 2'b01, "simul_lockloss");
      push(u + 7, 1'b1, 2'b01, 1'b1, 1'b0, "simul_priority");
      push_rng(u + 8,  u + 20, 1'b1, 2'b01, "simul_wait");
      push_rng(u + 21, u + 23, 1'b0, 2'b01, "simul_run");
      button_in = 1'b1;
      wait_neg(8);
      pll_locked = 1'b0;
      wait_neg(12);
      pll_locked = 1'b1;
      if (BTN_LAT == 7) button_in = 1'b0;
      wait_neg(4);
      pll_locked = 1'b0;
      if (BTN_LAT == 3) button_in = 1'b0;
      wait_neg(6);
      pll_locked = 1'b1;
      wait_neg(13);

      // reset_in asserted during a button HOLD with hold_cnt=5.
      p = cyc;
      r = p + 10;
      push_rng(p + 1, r + BTN_LAT - 1, 1'b0, 2'b01, "midrst_press");
      push_rng(r + BTN_LAT, r + BTN_LAT + 5, 1'b1, 2'b10, "midrst_hold");
      push(-1, 1'b1, 2'b00, 1'b1, 1'b0, "midrst_async");
      button_in = 1'b1;
      wait_neg(10);
      button_in = 1'b0;
      wait_neg(BTN_LAT + 5);
      #2 reset_in = 1'b1;
      p = cyc;
      push(p + 1, 1'b1, 2'b00, 1'b1, 1'b0, "midrst_held");
      push(p + 2, 1'b1, 2'b00, 1'b1, 1'b0, "midrst_held");
      wait_neg(2);
      p = cyc;
      expect_power_up(p, "midrst_power_up");
      reset_in = 1'b0;
      wait_neg(16);

      if (q.size() != 0) begin
         total += q.size();
         bad   += q.size();
         $display("FAIL pending: %0d expectations never compared", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
